id_inst_queue: RTL

- Parametrised instruction queue between IF and ID.
- Replaces the single IF/ID register and its stall-bubble scheme with a DEPTH-entry FIFO and a valid/ready handshake.
- A fetched instruction is never lost when ID stalls.
- Supports a branch flush that can keep a configurable number of the oldest surviving entries, so a MIPS delay slot survives the flush.

---
 rtl/id_inst_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/id_inst_queue.sv
// id_inst_queue
//    DEPTH-entry instruction FIFO sitting between IF and ID. IF pushes with a
//    valid/ready handshake, ID pops with a valid/ready handshake, so a fetched
//    instruction is never lost while ID stalls. A branch flush may keep the
//    KEEP oldest surviving entries (KEEP=1 keeps the MIPS delay slot).
//
//    Ports
//       clk       clock, all state updates on posedge
//       rst       synchronous active-high reset (dominates everything)
//       flush     branch redirect, applied at the end of the current cycle
//       if_valid  IF presents an instruction
//       if_pc     PC of the presented instruction
//       if_inst   presented instruction word
//       if_ready  queue can accept an instruction this cycle
//       id_valid  head entry is valid
//       id_pc     PC of the head entry (zero when empty)
//       id_inst   instruction of the head entry (zero when empty)
//       id_ready  ID consumes the head this cycle
//       count     current occupancy (registered)
module id_inst_queue #(
   parameter int DEPTH   = 4,
   parameter int PC_WD   = 32,
   parameter int INST_WD = 32,
   parameter int KEEP    = 1,
   parameter int CNT_WD  = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               if_valid,
   input  logic [PC_WD-1:0]   if_pc,
   input  logic [INST_WD-1:0] if_inst,
   output logic               if_ready,
   output logic               id_valid,
   output logic [PC_WD-1:0]   id_pc,
   output logic [INST_WD-1:0] id_inst,
   input  logic               id_ready,
   output logic [CNT_WD-1:0]  count
);

   localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_WD-1:0] DEPTH_C = CNT_WD'(DEPTH);
   localparam logic [CNT_WD-1:0] KEEP_C  = CNT_WD'(KEEP);

   generate
      if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("id_inst_queue: DEPTH must be a power of two in 2..16");
      end
      if (KEEP < 0 || KEEP >= DEPTH) begin : g_bad_keep
         $error("id_inst_queue: KEEP must be in 0..DEPTH-1");
      end
   endgenerate

   logic [PC_WD-1:0]   pc_mem_q   [DEPTH];
   logic [INST_WD-1:0] inst_mem_q [DEPTH];

   logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_WD-1:0] count_q,  count_d;

   logic              enq;
   logic              deq;
   logic [CNT_WD-1:0] cnt_after;

   // Outputs depend on registered state only; there is no input-to-output path.
   assign if_ready = (count_q < DEPTH_C);
   assign id_valid = (count_q != '0);
   assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign id_inst  = id_valid ? inst_mem_q[rd_ptr_q] : '0;
   assign count    = count_q;

   assign enq = if_valid & if_ready;
   assign deq = id_valid & id_ready;

   always_comb begin
      cnt_after = count_q + CNT_WD'(enq) - CNT_WD'(deq);
      rd_ptr_d  = rd_ptr_q + PTR_WD'(deq);
      count_d   = cnt_after;
      wr_ptr_d  = wr_ptr_q + PTR_WD'(enq);
      if (flush) begin
         // Survivors are the oldest entries after this cycle's handshakes, so
         // the write pointer is rebuilt from the new head rather than rewound.
         count_d  = (cnt_after > KEEP_C) ? KEEP_C : cnt_after;
         wr_ptr_d = rd_ptr_d + PTR_WD'(count_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; contents behind an invalid slot are unused.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem_q[wr_ptr_q]   <= if_pc;
         inst_mem_q[wr_ptr_q] <= if_inst;
      end
   end

endmodule
